// File: rtl/dm_trace_pkg.sv
// Shared types and constants for the data-memory store tracer.
package dm_trace_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    REVIEW  = 1'b1
  } trace_state_t;

  // Capture modes: stop and freeze when full, or keep overwriting the oldest entry.
  localparam int TRACE_STOP = 0;
  localparam int TRACE_RING = 1;

  // Width of the saturating dropped-store counter.
  localparam int DROP_W = 16;

endpackage

// File: rtl/dm_trace_mem.sv
// Trace storage: DEPTH x DATA_W register array, one synchronous write port,
// one combinational read port.
module dm_trace_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on an enabled clock edge.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  // NOTE: the array has no reset; validity is tracked by the tracer's entry count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_write_tracer.sv
// Captures data-memory stores into a trace buffer and lets the operator freeze
// the trace and step through it one LED-width slice at a time.
module dm_write_tracer
  import dm_trace_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int LED_W  = 8,
  parameter int MODE   = TRACE_STOP
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       wr_en_in,
  input  logic [DATA_W-1:0]          wr_data_in,
  input  logic                       freeze_in,
  input  logic                       step_in,
  output logic [LED_W-1:0]           led_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       full_out,
  output logic                       overflow_out,
  output logic [DROP_W-1:0]          dropped_out,
  output logic                       review_out
);

  localparam int NBYTES = DATA_W / LED_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  trace_state_t      state, state_n;
  logic [AW-1:0]     wr_ptr, wr_ptr_n;
  logic [CW-1:0]     count, count_n;
  logic [AW-1:0]     rd_idx, rd_idx_n;
  logic [BW-1:0]     byte_sel, byte_sel_n;
  logic              overflow, overflow_n;
  logic [DROP_W-1:0] dropped, dropped_n;
  logic [LED_W-1:0]  led, led_n;

  logic              full;
  logic              mem_we;
  logic [AW-1:0]     oldest_n;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_word;
  logic [BW-1:0]     sel;
  logic [SW-1:0]     bit_off;

  assign full = (count == CW'(DEPTH));

  dm_trace_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (CLOCK_50),
    .we     (mem_we),
    .waddr  (wr_ptr),
    .wdata  (wr_data_in),
    .raddr  (rd_addr),
    .rdata  (mem_rdata)
  );

  // Next-state, pointer/counter updates and the next display slice.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    count_n    = count;
    rd_idx_n   = rd_idx;
    byte_sel_n = byte_sel;
    overflow_n = overflow;
    dropped_n  = dropped;
    mem_we     = 1'b0;

    case (state)
      CAPTURE: begin
        if (wr_en_in) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            count_n  = count + CW'(1);
          end else if (MODE == TRACE_RING) begin
            // Ring mode: the slot at wr_ptr is the oldest entry when full.
            mem_we     = 1'b1;
            wr_ptr_n   = wr_ptr + AW'(1);
            overflow_n = 1'b1;
          end else begin
            // Stop mode never stays in CAPTURE while full; treat as a lost store.
            overflow_n = 1'b1;
            if (dropped != '1) dropped_n = dropped + DROP_W'(1);
          end
        end
        if (freeze_in || (MODE == TRACE_STOP && count_n == CW'(DEPTH))) begin
          state_n    = REVIEW;
          rd_idx_n   = '0;
          byte_sel_n = '0;
        end
      end
      REVIEW: begin
        if (wr_en_in) begin
          overflow_n = 1'b1;
          if (dropped != '1) dropped_n = dropped + DROP_W'(1);
        end
        if (step_in && count != '0) begin
          if (byte_sel == BW'(NBYTES - 1)) begin
            byte_sel_n = '0;
            rd_idx_n   = (CW'(rd_idx) == count - CW'(1)) ? '0 : rd_idx + AW'(1);
          end else begin
            byte_sel_n = byte_sel + BW'(1);
          end
        end
        if (!freeze_in && !(MODE == TRACE_STOP && full)) state_n = CAPTURE;
      end
    endcase

    // Display source: newest entry in CAPTURE, oldest+rd_idx in REVIEW,
    // forwarding the word being written this cycle.
    oldest_n = wr_ptr_n - count_n[AW-1:0];
    rd_addr  = (state_n == REVIEW) ? oldest_n + rd_idx_n : wr_ptr_n - AW'(1);
    rd_word  = (mem_we && rd_addr == wr_ptr) ? wr_data_in : mem_rdata;
    sel      = (state_n == REVIEW) ? byte_sel_n : '0;
    bit_off  = SW'(sel) * SW'(LED_W);
    led_n    = (count_n == '0) ? '0 : rd_word[bit_off +: LED_W];
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      count    <= '0;
      rd_idx   <= '0;
      byte_sel <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
      led      <= '0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      rd_idx   <= rd_idx_n;
      byte_sel <= byte_sel_n;
      overflow <= overflow_n;
      dropped  <= dropped_n;
      led      <= led_n;
    end
  end

  assign led_out      = led;
  assign count_out    = count;
  assign full_out     = full;
  assign overflow_out = overflow;
  assign dropped_out  = dropped;
  assign review_out   = (state == REVIEW);

endmodule

// File: tb/tb_dm_write_tracer.sv
// Self-checking bench for dm_write_tracer: directed scenarios plus randomized
// stimulus checked against a queue-based trace model.
module tb_dm_write_tracer;
  import dm_trace_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic        freeze = 1'b0;
  logic        step = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  // Three configurations share the same stimulus; sel picks the one under test.
  logic [7:0]  a_led, b_led, c_led;
  logic [4:0]  a_count;
  logic [2:0]  b_count, c_count;
  logic        a_full, b_full, c_full, a_ovf, b_ovf, c_ovf, a_rev, b_rev, c_rev;
  logic [15:0] a_drop, b_drop, c_drop;

  dm_write_tracer #(.DATA_W(64), .DEPTH(16), .LED_W(8), .MODE(TRACE_STOP)) u_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .wr_en_in(wr_en), .wr_data_in(wr_data),
    .freeze_in(freeze), .step_in(step), .led_out(a_led), .count_out(a_count),
    .full_out(a_full), .overflow_out(a_ovf), .dropped_out(a_drop), .review_out(a_rev));

  dm_write_tracer #(.DATA_W(64), .DEPTH(4), .LED_W(8), .MODE(TRACE_STOP)) u_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .wr_en_in(wr_en), .wr_data_in(wr_data),
    .freeze_in(freeze), .step_in(step), .led_out(b_led), .count_out(b_count),
    .full_out(b_full), .overflow_out(b_ovf), .dropped_out(b_drop), .review_out(b_rev));

  dm_write_tracer #(.DATA_W(64), .DEPTH(4), .LED_W(8), .MODE(TRACE_RING)) u_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .wr_en_in(wr_en), .wr_data_in(wr_data),
    .freeze_in(freeze), .step_in(step), .led_out(c_led), .count_out(c_count),
    .full_out(c_full), .overflow_out(c_ovf), .dropped_out(c_drop), .review_out(c_rev));

  int          sel = 0;
  logic [7:0]  obs_led;
  logic [4:0]  obs_count;
  logic        obs_full, obs_ovf, obs_rev;
  logic [15:0] obs_drop;

  always_comb begin
    case (sel)
      0: begin
        obs_led = a_led; obs_count = a_count; obs_full = a_full;
        obs_ovf = a_ovf; obs_drop = a_drop; obs_rev = a_rev;
      end
      1: begin
        obs_led = b_led; obs_count = {2'b00, b_count}; obs_full = b_full;
        obs_ovf = b_ovf; obs_drop = b_drop; obs_rev = b_rev;
      end
      default: begin
        obs_led = c_led; obs_count = {2'b00, c_count}; obs_full = c_full;
        obs_ovf = c_ovf; obs_drop = c_drop; obs_rev = c_rev;
      end
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: valid entries oldest-first, review position as a flat
  // slice index across all valid entries.
  logic [63:0] mq[$];
  bit          m_rev, m_ovf;
  int          m_pos, m_drop, m_depth, m_mode;

  function automatic logic [7:0] model_led();
    logic [63:0] w;
    if (mq.size() == 0) return 8'h00;
    if (m_rev) begin
      w = mq[m_pos / 8];
      return 8'(w >> ((m_pos % 8) * 8));
    end
    w = mq[mq.size() - 1];
    return w[7:0];
  endfunction

  task automatic model_step(input bit wr, input logic [63:0] d, input bit frz, input bit stp);
    if (!m_rev) begin
      if (wr) begin
        if (mq.size() < m_depth) mq.push_back(d);
        else if (m_mode == 1) begin
          void'(mq.pop_front());
          mq.push_back(d);
          m_ovf = 1'b1;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (frz || (m_mode == 0 && wr && mq.size() == m_depth)) begin
        m_rev = 1'b1;
        m_pos = 0;
      end
    end else begin
      if (wr) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (stp && mq.size() > 0) m_pos = (m_pos + 1) % (mq.size() * 8);
      if (!frz && !(m_mode == 0 && mq.size() == m_depth)) m_rev = 1'b0;
    end
  endtask

  task automatic tick(input bit wr, input logic [63:0] d, input bit frz, input bit stp);
    wr_en = wr; wr_data = d; freeze = frz; step = stp;
    @(posedge CLOCK_50);
    model_step(wr, d, frz, stp);
    @(negedge CLOCK_50);
    wr_en = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    m_depth = (s == 0) ? 16 : 4;
    m_mode = (s == 2) ? 1 : 0;
    reset = 1'b1; wr_en = 1'b0; freeze = 1'b0; step = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    mq.delete(); m_rev = 1'b0; m_ovf = 1'b0; m_pos = 0; m_drop = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    vectors++; if (obs_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", obs_count); end
    vectors++; if (obs_led !== 8'h00) begin miscompares++; $display("FAIL reset_led: got %h want 00", obs_led); end
    vectors++; if (obs_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", obs_full); end
    vectors++; if (obs_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", obs_ovf); end
    vectors++; if (obs_drop !== 16'h0) begin miscompares++; $display("FAIL reset_drop: got %h want 0000", obs_drop); end
    vectors++; if (obs_rev !== 1'b0) begin miscompares++; $display("FAIL reset_rev: got %b want 0", obs_rev); end
  endtask

  task automatic test_capture();
    tick(1, 64'h11, 0, 0);
    vectors++; if (obs_led !== 8'h11) begin miscompares++; $display("FAIL capture_led1: got %h want 11", obs_led); end
    tick(1, 64'h2222, 0, 0);
    tick(1, 64'h0102030405060708, 0, 0);
    vectors++; if (obs_count !== 5'd3) begin miscompares++; $display("FAIL capture_count: got %0d want 3", obs_count); end
    vectors++; if (obs_led !== 8'h08) begin miscompares++; $display("FAIL capture_led3: got %h want 08", obs_led); end
    vectors++; if (obs_ovf !== 1'b0) begin miscompares++; $display("FAIL capture_ovf: got %b want 0", obs_ovf); end
    vectors++; if (obs_rev !== 1'b0) begin miscompares++; $display("FAIL capture_rev: got %b want 0", obs_rev); end
  endtask

  task automatic test_review_steps();
    logic [7:0] exp_seq [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h22};
    tick(0, 64'h0, 1, 0);
    vectors++; if (obs_rev !== 1'b1) begin miscompares++; $display("FAIL review_enter: got %b want 1", obs_rev); end
    vectors++; if (obs_led !== 8'h11) begin miscompares++; $display("FAIL review_led0: got %h want 11", obs_led); end
    for (int i = 0; i < 9; i++) begin
      tick(0, 64'h0, 1, 1);
      vectors++;
      if (obs_led !== exp_seq[i]) begin
        miscompares++; $display("FAIL review_step%0d: got %h want %h", i + 1, obs_led, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stop_full();
    do_reset(1);
    for (int i = 1; i <= 4; i++) tick(1, 64'(i), 0, 0);
    vectors++; if (obs_full !== 1'b1) begin miscompares++; $display("FAIL stop_full: got %b want 1", obs_full); end
    vectors++; if (obs_rev !== 1'b1) begin miscompares++; $display("FAIL stop_rev: got %b want 1", obs_rev); end
    vectors++; if (obs_led !== 8'h01) begin miscompares++; $display("FAIL stop_led: got %h want 01", obs_led); end
    tick(1, 64'd5, 0, 0);
    vectors++; if (obs_drop !== 16'd1) begin miscompares++; $display("FAIL stop_drop: got %0d want 1", obs_drop); end
    vectors++; if (obs_ovf !== 1'b1) begin miscompares++; $display("FAIL stop_ovf: got %b want 1", obs_ovf); end
    tick(0, 64'h0, 0, 0);
    vectors++; if (obs_rev !== 1'b1) begin miscompares++; $display("FAIL stop_hold: got %b want 1", obs_rev); end
  endtask

  task automatic test_ring();
    logic [7:0] exp_entry [4] = '{8'h04, 8'h05, 8'h06, 8'h03};
    do_reset(2);
    for (int i = 1; i <= 6; i++) tick(1, 64'(i), 0, 0);
    tick(0, 64'h0, 1, 0);
    vectors++; if (obs_count !== 5'd4) begin miscompares++; $display("FAIL ring_count: got %0d want 4", obs_count); end
    vectors++; if (obs_ovf !== 1'b1) begin miscompares++; $display("FAIL ring_ovf: got %b want 1", obs_ovf); end
    vectors++; if (obs_led !== 8'h03) begin miscompares++; $display("FAIL ring_led0: got %h want 03", obs_led); end
    for (int e = 0; e < 4; e++) begin
      for (int b = 0; b < 7; b++) tick(0, 64'h0, 1, 1);
      vectors++; if (obs_led !== 8'h00) begin miscompares++; $display("FAIL ring_hi_byte%0d: got %h want 00", e, obs_led); end
      tick(0, 64'h0, 1, 1);
      vectors++;
      if (obs_led !== exp_entry[e]) begin
        miscompares++; $display("FAIL ring_entry%0d: got %h want %h", e, obs_led, exp_entry[e]);
      end
    end
  endtask

  task automatic test_freeze_same_cycle();
    do_reset(0);
    tick(1, 64'hAB, 1, 0);
    vectors++; if (obs_count !== 5'd1) begin miscompares++; $display("FAIL same_count: got %0d want 1", obs_count); end
    vectors++; if (obs_rev !== 1'b1) begin miscompares++; $display("FAIL same_rev: got %b want 1", obs_rev); end
    vectors++; if (obs_led !== 8'hAB) begin miscompares++; $display("FAIL same_led: got %h want ab", obs_led); end
    for (int i = 0; i < 3; i++) tick(1, 64'(i), 1, 0);
    vectors++; if (obs_drop !== 16'd3) begin miscompares++; $display("FAIL drop_three: got %0d want 3", obs_drop); end
    for (int i = 0; i < 65540; i++) tick(1, 64'(i), 1, 0);
    vectors++; if (obs_drop !== 16'hFFFF) begin miscompares++; $display("FAIL drop_sat: got %h want ffff", obs_drop); end
    vectors++; if (obs_count !== 5'd1) begin miscompares++; $display("FAIL drop_count: got %0d want 1", obs_count); end
  endtask

  task automatic test_reset_review();
    do_reset(2);
    for (int i = 1; i <= 4; i++) tick(1, 64'(i), 0, 0);
    tick(1, 64'h99, 1, 0);
    tick(1, 64'h77, 1, 1);
    vectors++; if (obs_count !== 5'd4) begin miscompares++; $display("FAIL rr_pre_count: got %0d want 4", obs_count); end
    vectors++; if (obs_drop !== 16'd1) begin miscompares++; $display("FAIL rr_pre_drop: got %0d want 1", obs_drop); end
    reset = 1'b1; wr_en = 1'b1; freeze = 1'b1; step = 1'b1; wr_data = 64'h55;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0; wr_en = 1'b0; freeze = 1'b0; step = 1'b0;
    mq.delete(); m_rev = 1'b0; m_ovf = 1'b0; m_pos = 0; m_drop = 0;
    vectors++; if (obs_count !== 5'd0) begin miscompares++; $display("FAIL rr_count: got %0d want 0", obs_count); end
    vectors++; if (obs_led !== 8'h00) begin miscompares++; $display("FAIL rr_led: got %h want 00", obs_led); end
    vectors++; if (obs_rev !== 1'b0) begin miscompares++; $display("FAIL rr_rev: got %b want 0", obs_rev); end
    vectors++; if (obs_drop !== 16'h0) begin miscompares++; $display("FAIL rr_drop: got %0d want 0", obs_drop); end
    vectors++; if (obs_ovf !== 1'b0) begin miscompares++; $display("FAIL rr_ovf: got %b want 0", obs_ovf); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    bit wr, frz, stp;
    for (int s = 0; s < 3; s++) begin
      do_reset(s);
      frz = 1'b0;
      for (int n = 0; n < 400; n++) begin
        wr  = ($urandom_range(0, 9) < 6);
        stp = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 19) == 0) frz = ~frz;
        tick(wr, {$urandom, $urandom}, frz, stp);
        got = {obs_count, obs_full, obs_ovf, obs_drop, obs_rev, obs_led};
        exp = {5'(mq.size()), (mq.size() == m_depth), m_ovf, 16'(m_drop), m_rev, model_led()};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL random cfg%0d cycle%0d: got %h want %h (count,full,ovf,drop,rev,led)", s, n, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_review_steps();
    test_stop_full();
    test_ring();
    test_freeze_same_cycle();
    test_reset_review();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
